stream_ingress_buffer: RTL

Sits directly downstream of the leaf packet parser's data-packet output and upstream of the leaf's user stream interface. Captures valid BFT data packets addressed to input ports 2..8 into a first-word-fall-through FIFO and presents them as a valid/ready stream split into port number and payload. Generates the registered `o_bft_ready` backpressure that the parser forwards to the BFT. Drops and counts any packet it cannot accept.

---
 rtl/bft_pkt_pkg.sv | 16 +
 rtl/ingress_fifo_ram.sv | 18 +
 rtl/stream_ingress_buffer.sv | 82 ++++++++
 3 files changed

// File: rtl/bft_pkt_pkg.sv
// bft_pkt_pkg: BFT packet field layout and the input-port range shared across the leaf.
package bft_pkt_pkg;
  localparam int PKT_BITS = 97;
  localparam int LEAF_BITS = 6;
  localparam int PORT_BITS = 4;
  localparam int PAYLOAD_W = PKT_BITS - 1 - LEAF_BITS - PORT_BITS;
  localparam int VALID_BIT = PKT_BITS - 1;
  localparam int LEAF_MSB = VALID_BIT - 1;
  localparam int LEAF_LSB = LEAF_MSB - LEAF_BITS + 1;
  localparam int PORT_MSB = LEAF_LSB - 1;
  localparam int PORT_LSB = PORT_MSB - PORT_BITS + 1;
  localparam int PAYLOAD_MSB = PORT_LSB - 1;
  localparam int PAYLOAD_LSB = 0;
  localparam int INPUT_PORT_MIN = 2;
  localparam int INPUT_PORT_MAX = 8;
endpackage

// File: rtl/ingress_fifo_ram.sv
// ingress_fifo_ram: distributed RAM, synchronous write, asynchronous read, no reset.
module ingress_fifo_ram #(
  parameter int WIDTH = 90,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/stream_ingress_buffer.sv
// stream_ingress_buffer: FWFT ingress FIFO for BFT data packets on ports 2..8, with
// registered backpressure, sticky overflow and a saturating drop counter.
module stream_ingress_buffer
  import bft_pkt_pkg::*;
#(
  parameter int PACKET_BITS = PKT_BITS,
  parameter int NUM_LEAF_BITS = LEAF_BITS,
  parameter int NUM_PORT_BITS = PORT_BITS,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_MARGIN = 4,
  localparam int PAYLOAD_BITS = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PACKET_BITS-1:0]   i_data_packet,
  output logic                     o_bft_ready,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_PORT_BITS-1:0] o_port,
  output logic [PAYLOAD_BITS-1:0]  o_payload,
  output logic [LW-1:0]            o_level,
  output logic                     o_overflow,
  output logic [15:0]              o_drop_count
);
  logic [AW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic ready_q, ready_d, overflow_q, overflow_d;
  logic [15:0] drop_q, drop_d;
  logic [NUM_PORT_BITS-1:0] port;
  logic cand, port_ok, full, pop, push, drop, unused_leaf;

  assign cand = i_data_packet[PACKET_BITS-1];
  assign port = i_data_packet[PAYLOAD_BITS +: NUM_PORT_BITS];
  assign unused_leaf = ^i_data_packet[PAYLOAD_BITS+NUM_PORT_BITS +: NUM_LEAF_BITS];
  assign port_ok = int'(port) >= INPUT_PORT_MIN && int'(port) <= INPUT_PORT_MAX;
  assign full = level_q == LW'(FIFO_DEPTH);
  assign pop = o_valid && i_ready;
  // a pop frees the slot this edge, so a full FIFO still accepts a packet when popped
  assign push = cand && port_ok && (!full || pop);
  assign drop = cand && !push;

  always_comb begin
    level_d = push && !pop ? level_q + LW'(1) : !push && pop ? level_q - LW'(1) : level_q;
    ready_d = (FIFO_DEPTH - int'(level_d)) > AFULL_MARGIN;
    overflow_d = overflow_q || (drop && port_ok);
    drop_d = drop_q + 16'(drop && drop_q != 16'hFFFF);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_q <= '0;
    end else begin
      wptr_q <= wptr_q + AW'(push);
      rptr_q <= rptr_q + AW'(pop);
      level_q <= level_d;
      ready_q <= ready_d;
      overflow_q <= overflow_d;
      drop_q <= drop_d;
    end

  ingress_fifo_ram #(.WIDTH(NUM_PORT_BITS + PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_ram (
    .clk(clk),
    .we_i(push),
    .waddr_i(wptr_q),
    .wdata_i(i_data_packet[PAYLOAD_BITS+NUM_PORT_BITS-1:0]),
    .raddr_i(rptr_q),
    .rdata_o({o_port, o_payload})
  );

  assign o_valid = level_q != '0;
  assign o_level = level_q;
  assign o_bft_ready = ready_q;
  assign o_overflow = overflow_q;
  assign o_drop_count = drop_q;
endmodule
